// File: rtl/cnn_layer_accel_result_packer.sv
// cnn_layer_accel_result_packer
//   Packs a stream of 16-bit conv results, 8 to a 128-bit word, into a
//   first-word-fall-through output FIFO. It counts results against a per-job
//   total, flushes the last partial word with a lane mask, and pulses job_done
//   once the FIFO has drained.
//   Optional feature macro: CNN_LAYER_ACCEL_RESULT_RELU_EN. When it is defined,
//   negative results are clamped to zero before they are packed.
module cnn_layer_accel_result_packer #(
    parameter int C_RESULT_WIDTH = 16,
    parameter int C_NUM_LANES    = 8,
    parameter int C_FIFO_DEPTH   = 16
) (
    input  logic                                    clk_core,
    input  logic                                    rst_n,
    input  logic                                    job_start,
    input  logic [21:0]                             num_results_cfg,
    output logic                                    busy,
    output logic                                    job_done,
    input  logic                                    result_valid,
    output logic                                    result_accept,
    input  logic [C_RESULT_WIDTH-1:0]               result_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [C_RESULT_WIDTH*C_NUM_LANES-1:0]   out_data,
    output logic [C_NUM_LANES-1:0]                  out_keep,
    output logic                                    out_last
);

    localparam int LW = $clog2(C_NUM_LANES);
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int DW = C_RESULT_WIDTH * C_NUM_LANES;
    localparam int EW = DW + C_NUM_LANES + 1;

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_DONE} state_t;

    state_t                                     r_state, w_state_nxt;
    logic [21:0]                                r_num_cfg;
    logic [21:0]                                r_count;
    logic [LW-1:0]                              r_lane_idx;
    logic [C_NUM_LANES-1:0][C_RESULT_WIDTH-1:0] r_pack;
    logic [C_NUM_LANES-1:0][C_RESULT_WIDTH-1:0] w_word_lanes;
    logic [C_NUM_LANES-1:0]                     w_keep;
    logic [C_RESULT_WIDTH-1:0]                  w_lane_val;
    logic [EW-1:0]                              r_mem [C_FIFO_DEPTH];
    logic [AW:0]                                r_wr_ptr, r_rd_ptr;
    logic                                       w_empty, w_full;
    logic                                       w_take, w_final, w_push, w_pop, w_start;

    // Optional ReLU on the incoming lane value; adds no latency.
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
    assign w_lane_val = result_data[C_RESULT_WIDTH-1] ? '0 : result_data;
`else
    assign w_lane_val = result_data;
`endif

    assign w_start = (r_state == S_IDLE) && job_start;
    assign w_take  = result_valid && result_accept;
    assign w_final = w_take && ((r_count + 22'd1) == r_num_cfg);
    assign w_push  = w_take && ((r_lane_idx == LW'(C_NUM_LANES - 1)) || w_final);
    assign w_pop   = out_valid && out_ready;

    // The outgoing word is the pack register plus the lane being written this cycle.
    // Lanes above the write index are already zero because the register clears on every push.
    for (genvar k = 0; k < C_NUM_LANES; k++) begin : g_lane
        assign w_word_lanes[k] = (r_lane_idx == LW'(k)) ? w_lane_val : r_pack[k];
        assign w_keep[k]       = (LW'(k) <= r_lane_idx);
    end

    // Accept depends only on registered state and FIFO level, never on result_valid.
    assign result_accept = (r_state == S_PACK) && !w_full;
    assign busy          = (r_state != S_IDLE);
    assign job_done      = (r_state == S_DONE);

    // FIFO flags. The extra pointer MSB distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Fall-through head. Outputs are forced to zero while the FIFO is empty,
    // so reset clears them without resetting the storage.
    assign out_valid = !w_empty;
    assign {out_last, out_keep, out_data} = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // FSM state register.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (job_start) w_state_nxt = (num_results_cfg == 22'd0) ? S_DONE : S_PACK;
            S_PACK:  if (w_final)   w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty)   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job configuration, result counter and lane index.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_num_cfg  <= '0;
            r_count    <= '0;
            r_lane_idx <= '0;
        end else if (w_start) begin
            r_num_cfg  <= num_results_cfg;
            r_count    <= '0;
            r_lane_idx <= '0;
        end else if (w_take) begin
            r_count    <= r_count + 22'd1;
            r_lane_idx <= w_push ? '0 : r_lane_idx + LW'(1);
        end
    end

    // Pack register: write the indexed lane, clear the whole word when it is pushed.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_pack <= '0;
        end else if (w_push || w_start) begin
            r_pack <= '0;
        end else if (w_take) begin
            for (int k = 0; k < C_NUM_LANES; k++)
                if (r_lane_idx == LW'(k)) r_pack[k] <= w_lane_val;
        end
    end

    // FIFO storage. Accept is gated by full, so a push never lands on a full FIFO.
    always_ff @(posedge clk_core) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_final, w_keep, DW'(w_word_lanes)};
    end

    // FIFO pointers. A push and a pop in the same cycle are both honoured.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule
